regfile_write_ctrl: RTL and testbench

//  Write-port controller for the 8 x 16-bit register block. Arbitrates two write requesters
//  (ALU writeback = port A, load/memory writeback = port B) round-robin onto the register D bus.

---
 rtl/cpu_regfile_pkg.sv | 13 +
 rtl/regfile_write_ctrl_if.sv | 32 +++
 rtl/regfile_write_ctrl_arb.sv | 30 +++
 rtl/regfile_write_ctrl.sv | 87 ++++++++
 tb/tb_regfile_write_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared types and sizes for the register block write port.
package cpu_regfile_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } wctrl_state_t;
endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Write requests, clear control and flattened D/Q buses
// between the pipeline, write controller and register block.
interface regfile_write_ctrl_if;
  import cpu_regfile_pkg::*;

  logic                   a_valid;
  reg_idx_t               a_addr;
  logic [DATA_W-1:0]      a_data;
  logic                   a_ready;
  logic                   b_valid;
  reg_idx_t               b_addr;
  logic [DATA_W-1:0]      b_data;
  logic                   b_ready;
  logic                   clr_req;
  logic                   busy;
  logic [NREG*DATA_W-1:0] q_bus;
  logic [NREG*DATA_W-1:0] d_bus;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output clr_req, q_bus,
    input  a_ready, b_ready, busy, d_bus
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  clr_req, q_bus,
    output a_ready, b_ready, busy, d_bus
  );
endinterface

// File: rtl/regfile_write_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer only
// moves when both requesters contend.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    unique case (1'b1)
      (req == 2'b11): begin
        gnt   = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-block write port: arbitration, hold and clear sweep.
// ZERO_REG_EN makes register 0 read-as-zero.
module regfile_write_ctrl
  import cpu_regfile_pkg::*;
(
  input logic             clk,
  input logic             rst,
  regfile_write_ctrl_if.slave bus
);
  wctrl_state_t state_q, state_d;
  reg_idx_t     sweep_idx_q, sweep_idx_d;
  logic         busy_q, busy_d;
  logic         grant_en;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic [NREG*DATA_W-1:0] d_mux;

  // clr_req beats any pending write in the same cycle
  assign grant_en = !rst && (state_q == IDLE) && !bus.clr_req;
  assign req      = {bus.b_valid, bus.a_valid} & {2{grant_en}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];
  assign bus.busy    = busy_q;
  assign bus.d_bus   = d_mux;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d     = CLEAR;
          sweep_idx_d = '0;
          busy_d      = 1'b1;
        end
      end
      CLEAR: begin
        if (sweep_idx_q == reg_idx_t'(NREG - 1)) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
          busy_d      = 1'b0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_mux = bus.q_bus;
    if (rst) begin
      d_mux = '0;
    end else if (state_q == CLEAR) begin
      d_mux[int'(sweep_idx_q)*DATA_W +: DATA_W] = '0;
    end else if (gnt[0]) begin
      d_mux[int'(bus.a_addr)*DATA_W +: DATA_W] = bus.a_data;
    end else if (gnt[1]) begin
      d_mux[int'(bus.b_addr)*DATA_W +: DATA_W] = bus.b_data;
    end
`ifdef ZERO_REG_EN
    d_mux[DATA_W-1:0] = '0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      busy_q      <= busy_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl with a behavioural
// register-file model and an emulated register block.
module tb_regfile_write_ctrl;
  import cpu_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_ctrl_if bus ();

  regfile_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] rf [NREG];

  always @(posedge clk)
    for (int i = 0; i < NREG; i++)
      rf[i] <= bus.d_bus[i*DATA_W +: DATA_W];

  for (genvar g = 0; g < NREG; g++) begin : g_q
    assign bus.q_bus[g*DATA_W +: DATA_W] = rf[g];
  end

  typedef struct {
    bit                port;
    reg_idx_t          addr;
    logic [DATA_W-1:0] data;
  } grant_t;

  grant_t            sb[$];
  logic [DATA_W-1:0] m_reg [NREG];
  int                m_left;
  int                m_pos;
  bit                m_prio;
  bit                chk_en;
  int                checks;
  int                errors;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(reg_idx_t a, logic [DATA_W-1:0] d);
    m_reg[a] = d;
  endtask

  // One clock: check last cycle's effects, drive, predict.
  task automatic cycle(
    input  bit r, input bit clr,
    input  bit av, input reg_idx_t aa, input logic [DATA_W-1:0] ad,
    input  bit bv, input reg_idx_t ba, input logic [DATA_W-1:0] bd,
    output bit ga, output bit gb
  );
    @(negedge clk);
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      for (int i = 0; i < NREG; i++)
        check($sformatf("reg%0d", i), 32'(rf[i]), 32'(m_reg[i]));
    end
    rst = r;  bus.clr_req = clr;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    ga = 0; gb = 0;
    if (r) begin
      m_left = 0; m_pos = 0; m_prio = 0;
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    end else if (m_left > 0) begin
      m_reg[m_pos] = '0;
      m_pos++;
      m_left--;
    end else if (clr) begin
      m_left = NREG;
      m_pos  = 0;
    end else begin
      if (av && bv) begin
        ga = (m_prio == 0);
        gb = !ga;
        m_prio = !m_prio;
      end else begin
        ga = av;
        gb = bv;
      end
      if (ga) begin model_write(aa, ad); sb.push_back('{0, aa, ad}); end
      if (gb) begin model_write(ba, bd); sb.push_back('{1, ba, bd}); end
    end
`ifdef ZERO_REG_EN
    m_reg[0] = '0;
`endif
  endtask

  task automatic idle(int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
  endtask

  // Hold both requests until each is granted (bounded).
  task automatic both(reg_idx_t aa, logic [DATA_W-1:0] ad,
                      reg_idx_t ba, logic [DATA_W-1:0] bd);
    bit pa = 1, pb = 1, ga, gb;
    int n = 0;
    while ((pa || pb) && n < 20) begin
      cycle(0, 0, pa, aa, ad, pb, ba, bd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
      n++;
    end
    check("both_timeout", 32'(pa || pb), 32'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants.
  initial begin
    grant_t e;
    logic [DATA_W-1:0] want;
    forever begin
      @(negedge clk);
      #3;
      if (bus.a_ready && bus.b_ready) check("dual_grant", 1, 0);
      if (bus.a_ready || bus.b_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", {bus.b_ready, bus.a_ready}, 0);
        end else begin
          e = sb.pop_front();
          want = e.data;
`ifdef ZERO_REG_EN
          if (e.addr == 0) want = '0;
`endif
          check("grant_port", 32'(bus.b_ready), 32'(e.port));
          check("d_bus_wr",
                32'(bus.d_bus[int'(e.addr)*DATA_W +: DATA_W]), 32'(want));
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        check("missing_grant", 0, {31'b0, 1'b1});
      end
    end
  end

  initial begin
    bit ga, gb, pa, pb;
    reg_idx_t aa, ba;
    logic [DATA_W-1:0] ad, bd;
    int n;
    checks = 0; errors = 0; chk_en = 0;
    m_left = 0; m_pos = 0; m_prio = 0;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    rst = 1; bus.clr_req = 0;
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    chk_en = 1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);

    cycle(0, 0, 1, 3, 16'hBEEF, 0, 0, 0, ga, gb);
    idle(1);
    check("t1_reg3", 32'(rf[3]), 32'h0000_BEEF);

    both(1, 16'h1111, 2, 16'h2222);
    both(4, 16'h4444, 6, 16'h6666);
    both(5, 16'hAAAA, 5, 16'hBBBB);
    idle(1);
    check("t4_reg5", 32'(rf[5]), 32'h0000_BBBB);

    for (int i = 0; i < NREG; i++)
      cycle(0, 0, 1, reg_idx_t'(i), 16'hFFFF, 0, 0, 0, ga, gb);
    cycle(0, 1, 1, 7, 16'h7777, 0, 0, 0, ga, gb);
    n = 0;
    ga = 0;
    while (!ga && n < 12) begin
      cycle(0, 0, 1, 7, 16'h7777, 0, 0, 0, ga, gb);
      n++;
    end
    check("t5_grant_after", n, NREG + 1);
    idle(1);
    check("t5_reg7", 32'(rf[7]), 32'h0000_7777);
    check("t5_reg2", 32'(rf[2]), 32'h0);

    cycle(0, 1, 0, 0, 0, 0, 0, 0, ga, gb);
    idle(4);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    cycle(0, 0, 1, 0, 16'h1234, 0, 0, 0, ga, gb);
    idle(1);

    pa = 0; pb = 0; aa = 0; ba = 0; ad = 0; bd = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(1, 0) == 1) begin
        pa = 1; aa = reg_idx_t'($urandom); ad = DATA_W'($urandom);
      end
      if (!pb && $urandom_range(1, 0) == 1) begin
        pb = 1; ba = reg_idx_t'($urandom); bd = DATA_W'($urandom);
      end
      cycle($urandom_range(99, 0) == 0, $urandom_range(24, 0) == 0,
            pa, aa, ad, pb, ba, bd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(2);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
